qu_res_station: RTL and testbench
=================================

Name: qu_res_station

Overview:
Tomasulo reservation station for the Qu core. It sits between decode/rename and the execution units.
- Accepts decoded ops whose operands are either values or producer tags, stored in res_st_cell_t entries.
- Snoops the common data bus (CDB) to capture pending operands.
- Issues ready ops to execution.
- The entry index is the result tag broadcast on the CDB; the entry is freed when that tag is broadcast.

Parameters:
DEPTH, RES_ST_DEPTH (32), number of entries; entry 0 is never allocated; tag 0 means "no pending producer".
OP_WIDTH, RES_ST_OP_WIDTH (14), opcode/control field width.
VDATA_WIDTH, RES_ST_VDATA_WIDTH (32), operand value width.
ADATA_WIDTH, RES_ST_ADATA_WIDTH (12), address/immediate field width.
TAG_WIDTH, $clog2(DEPTH), tag width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all entries (branch mispredict)
disp_valid  in  1  dispatch request
disp_ready  out  1  at least one free entry in 1..DEPTH-1
disp_op  in  OP_WIDTH  operation
disp_qj, disp_qk  in  TAG_WIDTH  producer tags; 0 = value present
disp_vj, disp_vk  in  VDATA_WIDTH  operand values, valid when matching q is 0
disp_a  in  ADATA_WIDTH  address/immediate
disp_tag  out  TAG_WIDTH  entry allocated on this dispatch handshake
cdb_valid  in  1  CDB broadcast
cdb_tag  in  TAG_WIDTH  producing entry
cdb_data  in  VDATA_WIDTH  result value
iss_valid  out  1  a ready, un-issued entry exists
iss_ready  in  1  execution unit accepts
iss_op  out  OP_WIDTH  issued op
iss_vj, iss_vk  out  VDATA_WIDTH  issued operands
iss_a  out  ADATA_WIDTH  issued address/immediate
iss_tag  out  TAG_WIDTH  tag of the issued entry

Behaviour:
- Reset (async, rst=1):
  - All busy and issued bits are 0.
  - Outputs: disp_ready=1 (DEPTH>1), disp_tag=1, iss_valid=0, iss_* = 0.
  - Takes effect immediately, including mid-operation; in-flight handshakes are dropped.
- State per entry: res_st_cell_t plus an internal issued bit. Entry 0 stays permanently not busy.
- Allocation:
  - disp_tag is the lowest-index non-busy entry in 1..DEPTH-1, computed combinationally from registered state.
  - disp_ready is 1 when any such entry exists.
  - On disp_valid & disp_ready, the entry is written at the clock edge: busy=1, issued=0.
- Dispatch-cycle bypass: if cdb_valid and cdb_tag!=0 and disp_qj==cdb_tag, store qj=0 and vj=cdb_data. The same rule applies to qk/vk.
- Wakeup: on cdb_valid with cdb_tag!=0, every busy entry with qj==cdb_tag gets qj=0, vj=cdb_data. The same applies to qk.
- Issue timing: a woken entry can issue one cycle later at the earliest.
- Ready: busy & !issued & qj==0 & qk==0.
- Issue select:
  - Lowest-index ready entry drives the iss_* outputs combinationally; iss_valid=1.
  - The same entry is held until the handshake.
  - On iss_valid & iss_ready, issued=1 at the edge.
- Dispatch-to-issue latency: minimum 1 cycle (entry written at edge N, iss_valid in cycle N+1).
- Free: on cdb_valid with cdb_tag==k and entry k busy, busy_k=0 and issued_k=0. A freed entry is allocatable from the next cycle; no same-cycle reuse.
- cdb_tag==0 or a tag of a non-busy entry: wakeup still applies; no free occurs.
- Simultaneous free and wakeup of the same entry: no conflict, because an entry's own tag never appears in its own qj/qk.
- flush: the next edge clears all busy/issued bits and overrides dispatch, wakeup and issue in that cycle. Same-cycle handshakes are discarded.
- Full: disp_ready=0; disp_valid is ignored and no state changes.
- Empty: iss_valid=0.
- Tag wrap: none; tags are entry indices.
- iss_* are don't-care when iss_valid=0; the RTL drives 0.

Decomposition:
- Add to qu_common:
  - RES_ST_TAG_NONE = 0.
  - cdb_t struct {valid, tag, data}.
  - res_st_issue_t struct {op, vj, vk, a, tag}.
- Sub-module qu_prio_enc: parameterised lowest-set-bit priority encoder, output {found, index}. Instantiated twice: allocation over ~busy masked with entry 0 excluded, and issue select over the ready vector.

Test Plan:
1. Reset: hold rst=1 mid-traffic -> immediately iss_valid=0, disp_ready=1, disp_tag=1; after release, the first dispatch gets tag 1 and the second gets tag 2.
2. Ready dispatch: op=0x0011, qj=qk=0, vj=5, vk=7, a=0x010 -> next cycle iss_valid=1, iss_tag=1, iss_vj=5, iss_vk=7; with iss_ready=1, iss_valid=0 the following cycle and the entry stays busy.
3. Wakeup: dispatch qj=3, vk=9 -> iss_valid=0; CDB tag 3, data 0xDEADBEEF -> next cycle iss_vj=0xDEADBEEF.
4. Bypass: dispatch qj=4 while cdb_valid, cdb_tag=4, data=42 -> next cycle iss_valid=1, iss_vj=42.
5. Full/free: fill 31 entries -> disp_ready=0, disp_valid ignored; CDB tag 17 -> next cycle disp_ready=1, disp_tag=17.
6. Flush: 5 busy entries plus concurrent dispatch with flush=1 -> next cycle all free, disp_tag=1, iss_valid=0.

Source files
------------

// File: rtl/qu_res_station_pkg.sv
// Shared types and sizes for the Qu reservation station.
// Provides entry/tag widths, the "no producer" tag, the CDB payload,
// the issue payload and the per-entry storage cell.
package qu_res_station_pkg;

    localparam int unsigned RES_ST_DEPTH       = 32;
    localparam int unsigned RES_ST_OP_WIDTH    = 14;
    localparam int unsigned RES_ST_VDATA_WIDTH = 32;
    localparam int unsigned RES_ST_ADATA_WIDTH = 12;
    localparam int unsigned RES_ST_TAG_WIDTH   = $clog2(RES_ST_DEPTH);

    // Tag 0 never names a producer; entry 0 is never allocated.
    localparam logic [RES_ST_TAG_WIDTH-1:0] RES_ST_TAG_NONE = '0;

    typedef struct packed {
        logic                          valid;
        logic [RES_ST_TAG_WIDTH-1:0]   tag;
        logic [RES_ST_VDATA_WIDTH-1:0] data;
    } cdb_t;

    typedef struct packed {
        logic [RES_ST_OP_WIDTH-1:0]    op;
        logic [RES_ST_VDATA_WIDTH-1:0] vj;
        logic [RES_ST_VDATA_WIDTH-1:0] vk;
        logic [RES_ST_ADATA_WIDTH-1:0] a;
        logic [RES_ST_TAG_WIDTH-1:0]   tag;
    } res_st_issue_t;

    typedef struct packed {
        logic                          busy;
        logic [RES_ST_OP_WIDTH-1:0]    op;
        logic [RES_ST_TAG_WIDTH-1:0]   qj;
        logic [RES_ST_VDATA_WIDTH-1:0] vj;
        logic [RES_ST_TAG_WIDTH-1:0]   qk;
        logic [RES_ST_VDATA_WIDTH-1:0] vk;
        logic [RES_ST_ADATA_WIDTH-1:0] a;
    } res_st_cell_t;

endpackage

// File: rtl/qu_res_station_prio_enc.sv
// Lowest-set-bit priority encoder.
// Ports: req (request vector), found (any bit set), index (lowest set bit, 0 if none).
module qu_prio_enc #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     req,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] index
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                index = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/qu_res_station.sv
// Tomasulo reservation station: accepts dispatched ops, snoops the CDB for
// pending operands, issues the lowest ready entry, frees an entry when its
// own tag is broadcast.
// Ports: clk/rst (async active-high), flush (sync clear);
//   dispatch: disp_valid/disp_ready, disp_op/qj/qk/vj/vk/a, disp_tag (allocated entry);
//   CDB: cdb_valid, cdb_tag, cdb_data;
//   issue: iss_valid/iss_ready, iss_op/vj/vk/a/tag.
module qu_res_station
    import qu_res_station_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [RES_ST_OP_WIDTH-1:0]    disp_op,
    input  logic [RES_ST_TAG_WIDTH-1:0]   disp_qj,
    input  logic [RES_ST_TAG_WIDTH-1:0]   disp_qk,
    input  logic [RES_ST_VDATA_WIDTH-1:0] disp_vj,
    input  logic [RES_ST_VDATA_WIDTH-1:0] disp_vk,
    input  logic [RES_ST_ADATA_WIDTH-1:0] disp_a,
    output logic [RES_ST_TAG_WIDTH-1:0]   disp_tag,
    input  logic                          cdb_valid,
    input  logic [RES_ST_TAG_WIDTH-1:0]   cdb_tag,
    input  logic [RES_ST_VDATA_WIDTH-1:0] cdb_data,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [RES_ST_OP_WIDTH-1:0]    iss_op,
    output logic [RES_ST_VDATA_WIDTH-1:0] iss_vj,
    output logic [RES_ST_VDATA_WIDTH-1:0] iss_vk,
    output logic [RES_ST_ADATA_WIDTH-1:0] iss_a,
    output logic [RES_ST_TAG_WIDTH-1:0]   iss_tag
);

    localparam int unsigned DEPTH = RES_ST_DEPTH;
    localparam int unsigned TW    = RES_ST_TAG_WIDTH;

    res_st_cell_t   cells [DEPTH];
    logic [DEPTH-1:0] issued;
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] ready_vec;
    logic             any_ready;
    logic [TW-1:0]    low_ready;
    logic             lock_valid;
    logic [TW-1:0]    lock_tag;
    logic             hold_ok;
    logic [TW-1:0]    sel_tag;
    logic             cdb_hit;
    cdb_t             cdb;
    res_st_cell_t     disp_cell;
    res_st_issue_t    iss_pkt;

    assign cdb     = '{valid: cdb_valid, tag: cdb_tag, data: cdb_data};
    assign cdb_hit = cdb.valid && (cdb.tag != RES_ST_TAG_NONE);

    // Allocation candidates exclude entry 0; ready needs both operands present.
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 1; i < int'(DEPTH); i++) begin
            free_vec[i] = !cells[i].busy;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            ready_vec[i] = cells[i].busy && !issued[i] &&
                           (cells[i].qj == RES_ST_TAG_NONE) &&
                           (cells[i].qk == RES_ST_TAG_NONE);
        end
    end

    qu_prio_enc #(.WIDTH(DEPTH), .IDX_WIDTH(TW)) u_alloc_enc (
        .req   (free_vec),
        .found (disp_ready),
        .index (disp_tag)
    );

    qu_prio_enc #(.WIDTH(DEPTH), .IDX_WIDTH(TW)) u_iss_enc (
        .req   (ready_vec),
        .found (any_ready),
        .index (low_ready)
    );

    // An offered entry stays selected until accepted, even if a lower one wakes.
    assign hold_ok   = lock_valid && ready_vec[lock_tag];
    assign sel_tag   = hold_ok ? lock_tag : low_ready;
    assign iss_valid = any_ready;

    always_comb begin
        iss_pkt = '0;
        if (iss_valid) begin
            iss_pkt.op  = cells[sel_tag].op;
            iss_pkt.vj  = cells[sel_tag].vj;
            iss_pkt.vk  = cells[sel_tag].vk;
            iss_pkt.a   = cells[sel_tag].a;
            iss_pkt.tag = sel_tag;
        end
    end

    assign iss_op  = iss_pkt.op;
    assign iss_vj  = iss_pkt.vj;
    assign iss_vk  = iss_pkt.vk;
    assign iss_a   = iss_pkt.a;
    assign iss_tag = iss_pkt.tag;

    // Incoming entry, with operands captured from a same-cycle CDB broadcast.
    always_comb begin
        disp_cell = '{busy: 1'b1, op: disp_op, qj: disp_qj, vj: disp_vj,
                      qk: disp_qk, vk: disp_vk, a: disp_a};
        if (cdb_hit && (disp_qj == cdb.tag)) begin
            disp_cell.qj = RES_ST_TAG_NONE;
            disp_cell.vj = cdb.data;
        end
        if (cdb_hit && (disp_qk == cdb.tag)) begin
            disp_cell.qk = RES_ST_TAG_NONE;
            disp_cell.vk = cdb.data;
        end
    end

    // Entry state: wakeup, issue mark, free, then dispatch write (later wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                cells[i] <= '0;
            end
            issued     <= '0;
            lock_valid <= 1'b0;
            lock_tag   <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                cells[i].busy <= 1'b0;
            end
            issued     <= '0;
            lock_valid <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (cdb_hit && cells[i].busy) begin
                    if (cells[i].qj == cdb.tag) begin
                        cells[i].qj <= RES_ST_TAG_NONE;
                        cells[i].vj <= cdb.data;
                    end
                    if (cells[i].qk == cdb.tag) begin
                        cells[i].qk <= RES_ST_TAG_NONE;
                        cells[i].vk <= cdb.data;
                    end
                end
            end
            if (iss_valid && iss_ready) begin
                issued[sel_tag] <= 1'b1;
            end
            if (cdb_hit && cells[cdb.tag].busy) begin
                cells[cdb.tag].busy <= 1'b0;
                issued[cdb.tag]     <= 1'b0;
            end
            if (disp_valid && disp_ready) begin
                cells[disp_tag]  <= disp_cell;
                issued[disp_tag] <= 1'b0;
            end
            lock_valid <= iss_valid && !iss_ready;
            lock_tag   <= sel_tag;
        end
    end

endmodule

// File: tb/tb_qu_res_station.sv
// Self-checking bench for qu_res_station: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_qu_res_station;
    import qu_res_station_pkg::*;

    localparam int D = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [13:0] disp_op = '0;
    logic [4:0]  disp_qj = '0, disp_qk = '0;
    logic [31:0] disp_vj = '0, disp_vk = '0;
    logic [11:0] disp_a = '0;
    logic [4:0]  disp_tag;
    logic        cdb_valid = 1'b0;
    logic [4:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        iss_valid;
    logic        iss_ready = 1'b0;
    logic [13:0] iss_op;
    logic [31:0] iss_vj, iss_vk;
    logic [11:0] iss_a;
    logic [4:0]  iss_tag;

    qu_res_station dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_a(disp_a), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_a(iss_a), .iss_tag(iss_tag)
    );

    always #5 clk = ~clk;

    // Behavioural model of the station contents.
    bit          m_busy [D];
    bit          m_iss  [D];
    int          m_qj   [D];
    int          m_qk   [D];
    logic [31:0] m_vj   [D];
    logic [31:0] m_vk   [D];
    logic [13:0] m_op   [D];
    logic [11:0] m_a    [D];
    bit          m_hold;
    int          m_hold_t;
    bit          e_dr, e_iv;
    int          e_dt, e_it;
    int          total = 0;
    int          bad = 0;
    bit          run = 1'b0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int i);
        return m_busy[i] && !m_iss[i] && m_qj[i] == 0 && m_qk[i] == 0;
    endfunction

    task automatic compute_exp;
        e_dr = 0; e_dt = 0; e_iv = 0; e_it = 0;
        for (int i = 1; i < D && !e_dr; i++)
            if (!m_busy[i]) begin e_dr = 1; e_dt = i; end
        for (int i = 0; i < D && !e_iv; i++)
            if (m_ready(i)) begin e_iv = 1; e_it = i; end
        if (m_hold && m_ready(m_hold_t)) e_it = m_hold_t;
    endtask

    task automatic model_reset;
        for (int i = 0; i < D; i++) begin m_busy[i] = 0; m_iss[i] = 0; end
        m_hold = 0; m_hold_t = 0;
    endtask

    // Apply one clock edge's worth of rules to the model using current inputs.
    task automatic model_step;
        int ct;
        bit hit;
        compute_exp;
        if (flush) begin model_reset; return; end
        ct  = int'(cdb_tag);
        hit = cdb_valid && ct != 0;
        for (int i = 0; i < D; i++) begin
            if (hit && m_busy[i] && m_qj[i] == ct) begin m_qj[i] = 0; m_vj[i] = cdb_data; end
            if (hit && m_busy[i] && m_qk[i] == ct) begin m_qk[i] = 0; m_vk[i] = cdb_data; end
        end
        if (e_iv && iss_ready) m_iss[e_it] = 1;
        if (hit && m_busy[ct]) begin m_busy[ct] = 0; m_iss[ct] = 0; end
        if (disp_valid && e_dr) begin
            m_busy[e_dt] = 1; m_iss[e_dt] = 0;
            m_op[e_dt] = disp_op; m_a[e_dt] = disp_a;
            m_qj[e_dt] = (hit && int'(disp_qj) == ct) ? 0 : int'(disp_qj);
            m_vj[e_dt] = (hit && int'(disp_qj) == ct) ? cdb_data : disp_vj;
            m_qk[e_dt] = (hit && int'(disp_qk) == ct) ? 0 : int'(disp_qk);
            m_vk[e_dt] = (hit && int'(disp_qk) == ct) ? cdb_data : disp_vk;
        end
        m_hold   = e_iv && !iss_ready;
        m_hold_t = e_it;
    endtask

    // Compare DUT outputs with the model mid-cycle.
    always @(negedge clk) begin
        if (run && !rst) begin
            compute_exp;
            cmp("disp_ready", 64'(disp_ready), 64'(e_dr));
            if (e_dr) cmp("disp_tag", 64'(disp_tag), 64'(e_dt));
            cmp("iss_valid", 64'(iss_valid), 64'(e_iv));
            if (e_iv) begin
                cmp("iss_tag", 64'(iss_tag), 64'(e_it));
                cmp("iss_op", 64'(iss_op), 64'(m_op[e_it]));
                cmp("iss_vj", 64'(iss_vj), 64'(m_vj[e_it]));
                cmp("iss_vk", 64'(iss_vk), 64'(m_vk[e_it]));
                cmp("iss_a", 64'(iss_a), 64'(m_a[e_it]));
            end else begin
                cmp("iss_idle_tag", 64'(iss_tag), 64'd0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        if (!rst) model_step;
        #1;
    endtask

    task automatic clear_inputs;
        flush = 0; disp_valid = 0; cdb_valid = 0; iss_ready = 0;
        disp_qj = '0; disp_qk = '0;
    endtask

    task automatic dispatch(input logic [13:0] op, input logic [4:0] qj, input logic [4:0] qk,
                            input logic [31:0] vj, input logic [31:0] vk, input logic [11:0] a);
        disp_valid = 1; disp_op = op; disp_qj = qj; disp_qk = qk;
        disp_vj = vj; disp_vk = vk; disp_a = a;
    endtask

    task automatic random_inputs;
        compute_exp;
        disp_valid = $urandom_range(0, 99) < 60;
        disp_op    = 14'($urandom);
        disp_vj    = $urandom;
        disp_vk    = $urandom;
        disp_a     = 12'($urandom);
        disp_qj    = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(1, 31));
        disp_qk    = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(1, 31));
        if (int'(disp_qj) == e_dt) disp_qj = 5'd0;
        if (int'(disp_qk) == e_dt) disp_qk = 5'd0;
        cdb_valid  = $urandom_range(0, 99) < 50;
        cdb_tag    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cdb_data   = $urandom;
        iss_ready  = $urandom_range(0, 99) < 60;
        flush      = $urandom_range(0, 99) < 2;
    endtask

    initial begin
        #12;
        cmp("rst_disp_ready", 64'(disp_ready), 64'd1);
        cmp("rst_disp_tag", 64'(disp_tag), 64'd1);
        cmp("rst_iss_valid", 64'(iss_valid), 64'd0);
        cmp("rst_iss_vj", 64'(iss_vj), 64'd0);
        @(negedge clk); #1;
        rst = 0; model_reset; run = 1;

        // Ready dispatch issues the next cycle.
        dispatch(14'h0011, 5'd0, 5'd0, 32'd5, 32'd7, 12'h010);
        cmp("t2_alloc_tag", 64'(disp_tag), 64'd1);
        tick; clear_inputs;
        cmp("t2_iss_valid", 64'(iss_valid), 64'd1);
        cmp("t2_iss_tag", 64'(iss_tag), 64'd1);
        cmp("t2_iss_vj", 64'(iss_vj), 64'd5);
        cmp("t2_iss_vk", 64'(iss_vk), 64'd7);
        cmp("t2_iss_op", 64'(iss_op), 64'h11);
        iss_ready = 1; tick; iss_ready = 0;
        cmp("t2_after_issue", 64'(iss_valid), 64'd0);
        cmp("t2_still_busy", 64'(disp_tag), 64'd2);

        // Wakeup from CDB.
        dispatch(14'h0022, 5'd3, 5'd0, 32'd0, 32'd9, 12'h020);
        tick; clear_inputs;
        cmp("t3_waiting", 64'(iss_valid), 64'd0);
        cdb_valid = 1; cdb_tag = 5'd3; cdb_data = 32'hDEADBEEF;
        tick; clear_inputs;
        cmp("t3_iss_valid", 64'(iss_valid), 64'd1);
        cmp("t3_iss_tag", 64'(iss_tag), 64'd2);
        cmp("t3_iss_vj", 64'(iss_vj), 64'hDEADBEEF);
        cmp("t3_iss_vk", 64'(iss_vk), 64'd9);
        iss_ready = 1; tick; iss_ready = 0;

        // Dispatch-cycle bypass.
        dispatch(14'h0033, 5'd4, 5'd0, 32'd0, 32'd1, 12'h030);
        cdb_valid = 1; cdb_tag = 5'd4; cdb_data = 32'd42;
        tick; clear_inputs;
        cmp("t4_iss_valid", 64'(iss_valid), 64'd1);
        cmp("t4_iss_tag", 64'(iss_tag), 64'd3);
        cmp("t4_iss_vj", 64'(iss_vj), 64'd42);
        iss_ready = 1; tick; iss_ready = 0;

        // Fill, full, free one.
        flush = 1; tick; flush = 0;
        cmp("t5_after_flush", 64'(disp_tag), 64'd1);
        dispatch(14'h0044, 5'd0, 5'd0, 32'd1, 32'd2, 12'h040);
        repeat (31) tick;
        cmp("t5_full", 64'(disp_ready), 64'd0);
        tick; clear_inputs;
        cmp("t5_full_ignored", 64'(disp_ready), 64'd0);
        cdb_valid = 1; cdb_tag = 5'd17; cdb_data = 32'd0;
        tick; clear_inputs;
        cmp("t5_freed_ready", 64'(disp_ready), 64'd1);
        cmp("t5_freed_tag", 64'(disp_tag), 64'd17);

        // Flush overrides concurrent dispatch and issue.
        dispatch(14'h0055, 5'd0, 5'd0, 32'd3, 32'd4, 12'h050);
        flush = 1; iss_ready = 1;
        tick; clear_inputs;
        cmp("t6_disp_tag", 64'(disp_tag), 64'd1);
        cmp("t6_iss_valid", 64'(iss_valid), 64'd0);
        cmp("t6_disp_ready", 64'(disp_ready), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            random_inputs;
            tick;
        end

        // Asynchronous reset mid-traffic.
        random_inputs; disp_valid = 1; flush = 0;
        #2; rst = 1; #1;
        cmp("t1_rst_iss_valid", 64'(iss_valid), 64'd0);
        cmp("t1_rst_disp_ready", 64'(disp_ready), 64'd1);
        cmp("t1_rst_disp_tag", 64'(disp_tag), 64'd1);
        model_reset;
        @(posedge clk);
        @(negedge clk); #1;
        clear_inputs; rst = 0;
        dispatch(14'h0066, 5'd0, 5'd0, 32'd8, 32'd9, 12'h060);
        cmp("t1_first_tag", 64'(disp_tag), 64'd1);
        tick;
        cmp("t1_second_tag", 64'(disp_tag), 64'd2);
        tick; clear_inputs;
        cmp("t1_third_tag", 64'(disp_tag), 64'd3);
        repeat (3) tick;

        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
